// File: rtl/tracker_pkg.sv
// Shared constants, state encoding and the row clamp helper for column_tracker.
// Contents:
//   H_ACTIVE, V_ACTIVE, Y_RESET : raster geometry and paddle reset row
//   SUM_W, CNT_W, COORD_W       : accumulator, count and coordinate widths
//   tracker_state_e             : frame-measurement FSM states
//   clamp_row()                 : clamp a wide value into [lo, hi]
package tracker_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned Y_RESET  = 240;

   // 0+1+..+479 = 114960 needs 17 bits; an all-lit column (480) needs 9 bits.
   localparam int unsigned SUM_W   = 17;
   localparam int unsigned CNT_W   = 9;
   localparam int unsigned COORD_W = 10;

   typedef enum logic [1:0] {
      StWaitFrame,
      StAccum,
      StDivide,
      StPublish
   } tracker_state_e;

   // The full-width compare keeps any stray high quotient bits from aliasing into range.
   function automatic logic [COORD_W-1:0] clamp_row(input logic [SUM_W-1:0]   val,
                                                    input logic [COORD_W-1:0] lo,
                                                    input logic [COORD_W-1:0] hi);
      if (val < SUM_W'(lo)) begin
         return lo;
      end else if (val > SUM_W'(hi)) begin
         return hi;
      end else begin
         return val[COORD_W-1:0];
      end
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider, SUM_W-bit dividend by CNT_W-bit divisor.
// One quotient bit per cycle; done_o pulses SUM_W cycles after start_i is accepted.
// start_i is ignored while a divide is running. Quotient is floored and stays
// stable on quotient_o until the next accepted start. Divisor must be non-zero.
// Ports:
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, aborts any divide in progress
//   start_i     : begin a divide with dividend_i / divisor_i
//   dividend_i  : SUM_W-bit dividend
//   divisor_i   : CNT_W-bit divisor
//   done_o      : one-cycle pulse, quotient_o valid from this cycle on
//   quotient_o  : SUM_W-bit quotient
module seq_divider
   import tracker_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [SUM_W-1:0] dividend_i,
   input  logic [CNT_W-1:0] divisor_i,
   output logic             done_o,
   output logic [SUM_W-1:0] quotient_o
);

   localparam int unsigned ITER_W = $clog2(SUM_W + 1);

   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [SUM_W-1:0]  quo_q, quo_d;
   logic [CNT_W-1:0]  dvs_q, dvs_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              run_q, run_d;
   logic              done_q, done_d;
   logic [CNT_W:0]    shifted;

   // Remainder is always < divisor, so the shifted partial fits in CNT_W+1 bits and the
   // restored remainder fits back into CNT_W bits.
   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      iter_d  = iter_q;
      run_d   = run_q;
      done_d  = 1'b0;
      shifted = {rem_q, quo_q[SUM_W-1]};

      if (run_q) begin
         if (shifted >= {1'b0, dvs_q}) begin
            rem_d = CNT_W'(shifted - {1'b0, dvs_q});
            quo_d = {quo_q[SUM_W-2:0], 1'b1};
         end else begin
            rem_d = shifted[CNT_W-1:0];
            quo_d = {quo_q[SUM_W-2:0], 1'b0};
         end
         iter_d = iter_q - ITER_W'(1);
         if (iter_q == ITER_W'(1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end else if (start_i) begin
         rem_d  = '0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
         iter_d = ITER_W'(SUM_W);
         run_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         iter_q <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         iter_q <= iter_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/column_tracker.sv
// Paddle tracker: watches the frame-buffer mask bit along one screen column, accumulates
// the count and row-sum of lit pixels over a frame, divides in vertical blanking and
// publishes a clamped paddle-centre row.
// Optional feature macro: COLUMN_TRACKER_SMOOTH_EN
//   defined   : paddle_y = clamp((3*paddle_y_prev + clamp(quotient)) >> 2)
//   undefined : paddle_y = clamp(quotient)
// Ports:
//   Clk        : system clock
//   Reset      : synchronous active-high reset
//   DrawX      : current raster X
//   DrawY      : current raster Y
//   pixel_on   : mask bit, valid PIX_LAT cycles after its DrawX/DrawY
//   paddle_y   : clamped centroid row of the last valid measurement
//   y_valid    : one-cycle pulse per completed frame (also when the value is held)
//   lit_count  : lit-pixel count of the last completed frame
//   busy       : high while dividing
// PIX_LAT must be at least 1.
module column_tracker
   import tracker_pkg::*;
#(
   parameter int unsigned COL_X      = 20,
   parameter int unsigned PIX_LAT    = 1,
   parameter int unsigned MIN_PIXELS = 8,
   parameter int unsigned HALF_SIZE  = 40
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic               pixel_on,
   output logic [COORD_W-1:0] paddle_y,
   output logic               y_valid,
   output logic [CNT_W-1:0]   lit_count,
   output logic               busy
);

   localparam logic [COORD_W-1:0] ColX    = COORD_W'(COL_X);
   localparam logic [COORD_W-1:0] VActive = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] YReset  = COORD_W'(Y_RESET);
   localparam logic [COORD_W-1:0] YLo     = COORD_W'(HALF_SIZE);
   localparam logic [COORD_W-1:0] YHi     = COORD_W'(V_ACTIVE - 1 - HALF_SIZE);
   localparam logic [CNT_W-1:0]   MinPix  = CNT_W'(MIN_PIXELS);

   tracker_state_e state_q, state_d;

   logic                            match, strobe;
   logic                            match_q;
   logic [PIX_LAT-1:0]              stb_q, stb_d;
   logic [PIX_LAT-1:0][COORD_W-1:0] dy_q, dy_d;
   logic                            samp;
   logic [COORD_W-1:0]              samp_y;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic               hold_q, hold_d;
   logic               started_q, started_d;
   logic [COORD_W-1:0] paddle_y_q, paddle_y_d;
   logic               y_valid_q, y_valid_d;
   logic [CNT_W-1:0]   lit_count_q, lit_count_d;

   logic               div_start, div_done;
   logic [SUM_W-1:0]   div_quo;
   logic [COORD_W-1:0] quo_clamped, new_y;

   // DrawX holds each pixel for two clocks, so only the rising edge of the match counts.
   assign match  = (DrawX == ColX) && (DrawY < VActive);
   assign strobe = match && !match_q;

   // Strobe and row travel together so the sample lines up with pixel_on.
   always_comb begin
      stb_d    = stb_q;
      dy_d     = dy_q;
      stb_d[0] = strobe;
      dy_d[0]  = DrawY;
      for (int unsigned i = 1; i < PIX_LAT; i++) begin
         stb_d[i] = stb_q[i-1];
         dy_d[i]  = dy_q[i-1];
      end
   end

   assign samp   = stb_q[PIX_LAT-1];
   assign samp_y = dy_q[PIX_LAT-1];

   seq_divider u_div (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .start_i    (div_start),
      .dividend_i (sum_q),
      .divisor_i  (cnt_q),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   assign quo_clamped = clamp_row(div_quo, YLo, YHi);

`ifdef COLUMN_TRACKER_SMOOTH_EN
   logic [COORD_W-1:0] mix;
   // 3*479 + 479 fits in 12 bits; the shift floors the average.
   assign mix   = COORD_W'((12'(paddle_y_q) * 12'd3 + 12'(quo_clamped)) >> 2);
   assign new_y = clamp_row(SUM_W'(mix), YLo, YHi);
`else
   assign new_y = quo_clamped;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      hold_d      = hold_q;
      started_d   = started_q;
      paddle_y_d  = paddle_y_q;
      lit_count_d = lit_count_q;
      y_valid_d   = 1'b0;
      div_start   = 1'b0;

      unique case (state_q)
         StWaitFrame: begin
            // Entering only at the frame origin means a wrap missed during blanking
            // skips a whole frame instead of measuring a partial one.
            if (DrawX == '0 && DrawY == '0) begin
               cnt_d   = '0;
               sum_d   = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (samp && pixel_on) begin
               cnt_d = cnt_q + CNT_W'(1);
               sum_d = sum_q + SUM_W'(samp_y);
            end
            if (DrawY == VActive) begin
               hold_d    = 1'b0;
               started_d = 1'b0;
               state_d   = StDivide;
            end
         end
         StDivide: begin
            if (!started_q) begin
               // Too few pixels is not a trustworthy centroid; also keeps divisor non-zero.
               if (cnt_q < MinPix || cnt_q == '0) begin
                  hold_d  = 1'b1;
                  state_d = StPublish;
               end else begin
                  div_start = 1'b1;
                  started_d = 1'b1;
               end
            end else if (div_done) begin
               state_d = StPublish;
            end
         end
         StPublish: begin
            y_valid_d   = 1'b1;
            lit_count_d = cnt_q;
            if (!hold_q) begin
               paddle_y_d = new_y;
            end
            state_d = StWaitFrame;
         end
         default: state_d = StWaitFrame;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= StWaitFrame;
         match_q     <= 1'b0;
         stb_q       <= '0;
         dy_q        <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         hold_q      <= 1'b0;
         started_q   <= 1'b0;
         paddle_y_q  <= YReset;
         y_valid_q   <= 1'b0;
         lit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         match_q     <= match;
         stb_q       <= stb_d;
         dy_q        <= dy_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         hold_q      <= hold_d;
         started_q   <= started_d;
         paddle_y_q  <= paddle_y_d;
         y_valid_q   <= y_valid_d;
         lit_count_q <= lit_count_d;
      end
   end

   assign paddle_y  = paddle_y_q;
   assign y_valid   = y_valid_q;
   assign lit_count = lit_count_q;
   assign busy      = (state_q == StDivide);

endmodule

// File: tb/tb_column_tracker.sv
// Bench for column_tracker (COL_X=20, PIX_LAT=1). A compressed raster presents a few
// columns per row (each held two clocks) with rows 0..489; a frame-buffer model drives
// pixel_on one cycle late. Expected results per frame are derived from the lit-row set
// with plain arithmetic and queued; a monitor pops them on each y_valid pulse.
module tb_column_tracker;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [9:0] DrawX, DrawY;
   logic       pixel_on;
   logic [9:0] paddle_y;
   logic       y_valid;
   logic [8:0] lit_count;
   logic       busy;

   always #10 Clk = ~Clk;

   column_tracker #(
      .COL_X      (20),
      .PIX_LAT    (1),
      .MIN_PIXELS (8),
      .HALF_SIZE  (40)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .pixel_on  (pixel_on),
      .paddle_y  (paddle_y),
      .y_valid   (y_valid),
      .lit_count (lit_count),
      .busy      (busy)
   );

   typedef struct {
      int py;
      int lc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;
   bit   c19[480];
   bit   c20[480];
   bit   c21[480];
   int   px = 600;
   int   py = 500;
   int   model_y = 240;
   int   xs[5] = '{0, 19, 20, 21, 300};

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic bit lit(input int x, input int y);
      if (y < 0 || y >= 480) return 1'b0;
      case (x)
         19:      return c19[y];
         20:      return c20[y];
         21:      return c21[y];
         300:     return (y % 3) == 0;
         0:       return (y % 2) == 1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int clamp(input int v);
      if (v < 40) return 40;
      if (v > 439) return 439;
      return v;
   endfunction

   // pixel_on reflects the coordinates presented one cycle earlier.
   task automatic cyc(input int x, input int y);
      @(posedge Clk);
      #1;
      pixel_on = lit(px, py);
      px = x;
      py = y;
      DrawX = 10'(x);
      DrawY = 10'(y);
   endtask

   task automatic clear_cols();
      for (int y = 0; y < 480; y++) begin
         c19[y] = 1'b0;
         c20[y] = 1'b0;
         c21[y] = 1'b0;
      end
   endtask

   task automatic set20(input int lo, input int hi);
      clear_cols();
      for (int y = lo; y <= hi; y++) c20[y] = 1'b1;
   endtask

   task automatic push_expect();
      int cnt = 0;
      int sum = 0;
      int c;
      for (int y = 0; y < 480; y++) begin
         if (c20[y]) begin
            cnt++;
            sum += y;
         end
      end
      if (cnt >= 8) begin
         c = clamp(sum / cnt);
`ifdef COLUMN_TRACKER_SMOOTH_EN
         model_y = clamp((3 * model_y + c) / 4);
`else
         model_y = c;
`endif
      end
      exp_q.push_back('{model_y, cnt});
   endtask

   // abort: pulse Reset a few cycles into the divide of this frame.
   task automatic run_frame(input bit abort);
      int k = 0;
      for (int y = 0; y < 490; y++) begin
         if (y == 480 && !abort) push_expect();
         for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < 2; r++) begin
               cyc(xs[i], y);
               if (abort && y == 480) begin
                  if (k == 5) begin
                     check("busy_in_divide", busy, 1);
                     Reset = 1'b1;
                  end else if (k == 6) begin
                     Reset = 1'b0;
                     check("abort_paddle_y", paddle_y, 240);
                     check("abort_busy", busy, 0);
                     check("abort_y_valid", y_valid, 0);
                     model_y = 240;
                  end
                  k++;
               end
            end
         end
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset && y_valid) begin
         if (exp_q.size() == 0) begin
            check("y_valid_without_expect", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("paddle_y", paddle_y, e.py);
            check("lit_count", lit_count, e.lc);
         end
      end
   end

   initial begin
      int dens;
      Reset    = 1'b1;
      DrawX    = 10'd600;
      DrawY    = 10'd500;
      pixel_on = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_paddle_y", paddle_y, 240);
      check("reset_y_valid", y_valid, 0);
      check("reset_lit_count", lit_count, 0);
      check("reset_busy", busy, 0);
      Reset = 1'b0;

      set20(100, 180); run_frame(1'b0);    // mean 140
      run_frame(1'b0);
      set20(100, 179); run_frame(1'b0);    // 80 rows, sum 11160
      set20(0, 9);     run_frame(1'b0);    // quotient 4, low clamp
      set20(470, 479); run_frame(1'b0);    // quotient 474, high clamp
      set20(100, 179); run_frame(1'b0);
      set20(100, 104); run_frame(1'b0);    // too few: hold
      clear_cols();
      for (int y = 0; y < 480; y++) begin
         c19[y] = 1'b1;
         c21[y] = 1'b1;
      end
      run_frame(1'b0);                     // neighbours only: count 0
      set20(200, 260); run_frame(1'b1);    // aborted by reset
      run_frame(1'b0);                     // measures normally afterwards
      for (int f = 0; f < 2; f++) begin
         dens = $urandom_range(1, 60);
         for (int y = 0; y < 480; y++) begin
            c20[y] = ($urandom_range(0, 99) < dens);
            c19[y] = $urandom_range(0, 1) == 1;
            c21[y] = $urandom_range(0, 1) == 1;
         end
         run_frame(1'b0);
      end
      set20(0, 479); run_frame(1'b0);      // all lit: 480 rows

      repeat (40) cyc(600, 500);
      check("pending_expects", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
